// File: rtl/clear_ram.sv
// clear_ram: single-port RAM with per-lane write enables, read-valid strobe and a clear engine.
// Optional macro CLEAR_RAM_WRITE_FIRST_EN selects write-first per-lane bypass on same-address collisions.
`timescale 1ns/1ps
`default_nettype none

module clear_ram #(
   parameter int              SIZE        = 16,
   parameter int              DEPTH       = 64,
   parameter int              LANES       = 2,
   parameter logic [SIZE-1:0] CLEAR_VALUE = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(DEPTH)-1:0] address,
   input  logic [SIZE-1:0]          write_data,
   input  logic [LANES-1:0]         write_en,
   input  logic                     read_en,
   input  logic                     clear,
   output logic [SIZE-1:0]          read_data,
   output logic                     read_valid,
   output logic                     busy
);

   localparam int              AW      = $clog2(DEPTH);
   localparam int              LW      = SIZE / LANES;
   localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);
   localparam logic [AW:0]     DEPTH_W = (AW + 1)'(DEPTH);

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t          state;
   logic [AW-1:0]   counter;
   logic [SIZE-1:0] ram [0:DEPTH-1];
   logic            in_range;
   logic            do_write;
   logic [SIZE-1:0] read_word;

   assign busy     = (state == CLEAR);
   assign in_range = ({1'b0, address} < DEPTH_W);
   assign do_write = (state == READY) && !clear && (|write_en) && in_range;

   // Array has no reset so it can map onto block RAM; the clear engine is its only writer while busy.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         ram[counter] <= CLEAR_VALUE;
      end else if (do_write) begin
         for (int i = 0; i < LANES; i++) begin
            if (write_en[i]) begin
               ram[address][i*LW +: LW] <= write_data[i*LW +: LW];
            end
         end
      end
   end

   always_comb begin
      read_word = CLEAR_VALUE;
      if (in_range) begin
         read_word = ram[address];
`ifdef CLEAR_RAM_WRITE_FIRST_EN
         for (int i = 0; i < LANES; i++) begin
            if (write_en[i]) begin
               read_word[i*LW +: LW] = write_data[i*LW +: LW];
            end
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= CLEAR;
         counter    <= '0;
         read_data  <= '0;
         read_valid <= 1'b0;
      end else begin
         read_valid <= 1'b0;
         case (state)
            CLEAR: begin
               counter <= counter + 1'b1;
               if (counter == LAST) begin
                  state   <= READY;
                  counter <= '0;
               end
            end
            READY: begin
               // A clear request wins over any read or write in the same cycle.
               if (clear) begin
                  state   <= CLEAR;
                  counter <= '0;
               end else if (read_en) begin
                  read_data  <= read_word;
                  read_valid <= 1'b1;
               end
            end
            default: begin
               state   <= CLEAR;
               counter <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/clear_ram.md
# clear_ram

Parametrised single-port RAM with per-lane byte enables, a read-valid handshake and a built-in clear engine that fills every entry with a constant after reset or on command. It is the default scratch memory for game state and frame data: consumers issue reads and writes at one address per cycle and use `busy` and `read_valid` instead of counting cycles themselves. Large instances map to block RAM; the clear engine is the only writer while it runs.

## Interface
- `SIZE`, default 16: bits per word; must be a multiple of `LANES`.
- `DEPTH`, default 64: number of words; need not be a power of two; minimum 2.
- `LANES`, default 2: number of write-enable lanes, each `SIZE/LANES` bits wide.
- `CLEAR_VALUE`, default 0: `SIZE`-bit word written to every entry during clear.

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `address` input `$clog2(DEPTH)`: word address for the read and/or write this cycle.
- `write_data` input `SIZE`: data to write; lane i is bits `[(i+1)*SIZE/LANES-1 : i*SIZE/LANES]`.
- `write_en` input `LANES`: per-lane write enable; any bit set is a write request.
- `read_en` input 1: read request.
- `clear` input 1: single-cycle pulse that starts a full clear.
- `read_data` output `SIZE`: registered read result.
- `read_valid` output 1: high for exactly one cycle when `read_data` carries a new result.
- `busy` output 1: high while the clear engine owns the array; requests are dropped.

## Operation
- Two states, registered: `CLEAR` and `READY`. `busy` = (state == `CLEAR`), decoded from the state register.
- Reset: state `CLEAR`, clear counter 0, `read_data` = 0, `read_valid` = 0, `busy` = 1.
- `CLEAR`: each cycle writes `CLEAR_VALUE` to `ram[counter]` and increments the counter. The cycle that writes `DEPTH-1` moves the state to `READY`. All `read_en`, `write_en` and `clear` inputs are ignored. `read_valid` stays 0 and `read_data` holds its value.
- `READY`, `clear` high: the state moves to `CLEAR` with counter 0. Any read or write in the same cycle is dropped, so `clear` has priority.
- `READY`, write: each lane with its `write_en` bit set updates that lane of `ram[address]`; other lanes keep their value.
- `READY`, read: `read_data` takes `ram[address]` and `read_valid` goes to 1 for the next cycle only. When no read is accepted, `read_data` holds its last value.
- Simultaneous read and write to the same address: the result depends on the configuration described under Configuration.
- Address out of range (`address >= DEPTH`): the write is dropped. A read returns `CLEAR_VALUE` with `read_valid` = 1.
- Reset asserted mid-clear or mid-read: the block returns to reset values immediately and the clear restarts from address 0.

## Timing
- Read latency is 1 cycle: a request accepted at edge N gives `read_data`/`read_valid` after edge N.
- A write is visible to a read issued on the following cycle.
- A full clear takes exactly `DEPTH` cycles: `busy` falls after the `DEPTH`-th rising edge following the `rst` release, or following the edge that samples `clear`.
- Back-to-back reads give one result per cycle, with `read_valid` held high continuously.

## Configuration
- `CLEAR_RAM_WRITE_FIRST_EN` defined: a read and write to the same address in the same cycle return new data on written lanes and old data on unwritten lanes (write-first, per-lane bypass).
- `CLEAR_RAM_WRITE_FIRST_EN` undefined: the same case returns the entire old word (read-first). A later read returns the new data.

## Test plan
- Clear after reset: release `rst` with DEPTH=64 and `CLEAR_VALUE`=16'hA5A5 -> `busy`=1 for exactly 64 cycles; reads of addresses 0, 31 and 63 then return 16'hA5A5, each with one `read_valid` pulse.
- Lane enables: write 16'h1234 with `write_en`=2'b11 to address 5, then 16'hFFFF with 2'b01 -> a read of address 5 returns 16'h12FF.
- Read/write collision: address 9 holds 16'h0000; in one cycle set `read_en`=1 and write 16'hBEEF with 2'b10 -> returns 16'hBE00 with the macro and 16'h0000 without; a following read returns 16'hBE00 in both builds.
- `clear` priority and busy drop: in one cycle pulse `clear` and write 16'h5555 to address 3 -> the write is lost; all requests are ignored while `busy`=1; afterwards address 3 reads `CLEAR_VALUE` and `read_valid` never pulses during the clear.
- Reset mid-clear, non-power-of-two: with DEPTH=40, assert `rst` at clear cycle 20 and release it -> `busy` lasts a further 40 cycles; a read of address 45 returns `CLEAR_VALUE` and a write to address 45 has no effect on any entry.
- Streaming: issue reads of addresses 0 to 7 on consecutive cycles after writing value = address -> `read_valid` stays high for 8 cycles and the data sequence is 0 to 7 with 1-cycle latency.
